// File: rtl/rs_pool_pkg.sv
// rs_pool_pkg -- shared types for the reservation-station pool.
//   fu_op_t     : functional-unit operation code
//   nzcv_t      : condition flags
//   rs_entry_t  : entry layout at the default operand/tag widths; rs_pool
//                 keeps the same field order at its parameterised widths
//   is_mem_op() : true for ops whose operand a is base + offset
package rs_pool_pkg;

    localparam int RS_DEPTH_DEF   = 8;
    localparam int RS_NUM_CDB_DEF = 2;
    localparam int RS_GPR_W_DEF   = 64;
    localparam int RS_TAG_W_DEF   = 6;

    typedef enum logic [3:0] {
        FU_OP_ADD,
        FU_OP_SUB,
        FU_OP_AND,
        FU_OP_ORR,
        FU_OP_EOR,
        FU_OP_LSL,
        FU_OP_LSR,
        FU_OP_CMP,
        FU_OP_BCOND,
        FU_OP_LDUR,
        FU_OP_STUR
    } fu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    typedef struct packed {
        logic                    valid;
        fu_op_t                  op;
        logic [RS_TAG_W_DEF-1:0] dst_tag;
        logic                    a_vld;
        logic [RS_GPR_W_DEF-1:0] a_val;
        logic [RS_TAG_W_DEF-1:0] a_tag;
        logic                    b_vld;
        logic [RS_GPR_W_DEF-1:0] b_val;
        logic [RS_TAG_W_DEF-1:0] b_tag;
        logic                    uses_nzcv;
        logic                    set_nzcv;
        logic                    f_vld;
        nzcv_t                   nzcv;
        logic [RS_TAG_W_DEF-1:0] f_tag;
    } rs_entry_t;

    function automatic logic is_mem_op(fu_op_t op);
        return (op == FU_OP_LDUR) || (op == FU_OP_STUR);
    endfunction

endpackage

// File: rtl/rs_pool_if.sv
// rs_pool_if -- bus bundle for rs_pool: flush, allocate handshake and
// payload, CDB broadcast ports, pending-store count, issue handshake and
// payload, occupancy count.
//   master : producer side (dispatch / CDB / issue consumer)
//   slave  : the pool itself
interface rs_pool_if #(
    parameter int DEPTH   = 8,
    parameter int NUM_CDB = 2,
    parameter int GPR_W   = 64,
    parameter int TAG_W   = 6
);
    import rs_pool_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                              in_flush;
    logic                              in_alloc_valid;
    logic                              out_alloc_ready;
    fu_op_t                            in_alloc_op;
    logic [TAG_W-1:0]                  in_alloc_dst_tag;
    logic                              in_alloc_a_valid;
    logic [GPR_W-1:0]                  in_alloc_a_value;
    logic [TAG_W-1:0]                  in_alloc_a_tag;
    logic                              in_alloc_b_valid;
    logic [GPR_W-1:0]                  in_alloc_b_value;
    logic [TAG_W-1:0]                  in_alloc_b_tag;
    logic                              in_alloc_uses_nzcv;
    logic                              in_alloc_set_nzcv;
    logic                              in_alloc_nzcv_valid;
    nzcv_t                             in_alloc_nzcv;
    logic [TAG_W-1:0]                  in_alloc_nzcv_tag;
    logic [NUM_CDB-1:0]                in_cdb_valid;
    logic [NUM_CDB-1:0][TAG_W-1:0]     in_cdb_tag;
    logic [NUM_CDB-1:0][GPR_W-1:0]     in_cdb_value;
    logic [NUM_CDB-1:0]                in_cdb_set_nzcv;
    nzcv_t [NUM_CDB-1:0]               in_cdb_nzcv;
    logic [7:0]                        in_pending_stur_count;
    logic                              out_issue_valid;
    logic                              in_issue_ready;
    fu_op_t                            out_issue_op;
    logic [GPR_W-1:0]                  out_issue_val_a;
    logic [GPR_W-1:0]                  out_issue_val_b;
    nzcv_t                             out_issue_nzcv;
    logic                              out_issue_set_nzcv;
    logic [TAG_W-1:0]                  out_issue_dst_tag;
    logic [CNT_W-1:0]                  out_count;

    modport master (
        output in_flush, in_alloc_valid, in_alloc_op, in_alloc_dst_tag,
               in_alloc_a_valid, in_alloc_a_value, in_alloc_a_tag,
               in_alloc_b_valid, in_alloc_b_value, in_alloc_b_tag,
               in_alloc_uses_nzcv, in_alloc_set_nzcv, in_alloc_nzcv_valid,
               in_alloc_nzcv, in_alloc_nzcv_tag,
               in_cdb_valid, in_cdb_tag, in_cdb_value, in_cdb_set_nzcv,
               in_cdb_nzcv, in_pending_stur_count, in_issue_ready,
        input  out_alloc_ready, out_issue_valid, out_issue_op,
               out_issue_val_a, out_issue_val_b, out_issue_nzcv,
               out_issue_set_nzcv, out_issue_dst_tag, out_count
    );

    modport slave (
        input  in_flush, in_alloc_valid, in_alloc_op, in_alloc_dst_tag,
               in_alloc_a_valid, in_alloc_a_value, in_alloc_a_tag,
               in_alloc_b_valid, in_alloc_b_value, in_alloc_b_tag,
               in_alloc_uses_nzcv, in_alloc_set_nzcv, in_alloc_nzcv_valid,
               in_alloc_nzcv, in_alloc_nzcv_tag,
               in_cdb_valid, in_cdb_tag, in_cdb_value, in_cdb_set_nzcv,
               in_cdb_nzcv, in_pending_stur_count, in_issue_ready,
        output out_alloc_ready, out_issue_valid, out_issue_op,
               out_issue_val_a, out_issue_val_b, out_issue_nzcv,
               out_issue_set_nzcv, out_issue_dst_tag, out_count
    );

endinterface

// File: rtl/rs_pool_select.sv
// rs_pool_select -- picks one ready entry for issue.
//   ready_i : per-entry ready vector
//   older_i : age matrix, older_i[i][j]=1 when entry i was allocated before
//             entry j (only with RS_AGE_SELECT_EN)
//   grant_o : one-hot selected entry
//   valid_o : some entry is ready
// RS_AGE_SELECT_EN defined   -> oldest ready entry wins.
// RS_AGE_SELECT_EN undefined -> lowest-index ready entry wins.
module rs_pool_select #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]            ready_i,
`ifdef RS_AGE_SELECT_EN
    input  logic [DEPTH-1:0][DEPTH-1:0] older_i,
`endif
    output logic [DEPTH-1:0]            grant_o,
    output logic                        valid_o
);

    assign valid_o = |ready_i;

`ifdef RS_AGE_SELECT_EN
    // An entry wins when no other ready entry is older than it. The matrix
    // is a strict order over valid entries, so exactly one ready entry wins.
    always_comb begin
        grant_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant_o[i] = ready_i[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ready_i[j] && !older_i[i][j])
                    grant_o[i] = 1'b0;
            end
        end
    end
`else
    // Isolate the lowest set bit.
    assign grant_o = ready_i & (~ready_i + DEPTH'(1));
`endif

endmodule

// File: rtl/rs_pool.sv
// rs_pool -- reservation-station pool with CDB wakeup and single issue port.
//   in_clk  : clock
//   in_rst  : synchronous active-high reset
//   bus     : rs_pool_if.slave -- flush, alloc handshake/payload, CDB ports,
//             pending-store count, issue handshake/payload, out_count
// Optional: RS_AGE_SELECT_EN selects the oldest ready entry through an age
// matrix; without it the lowest-index ready entry issues.
module rs_pool
    import rs_pool_pkg::*;
#(
    parameter int DEPTH   = RS_DEPTH_DEF,
    parameter int NUM_CDB = RS_NUM_CDB_DEF,
    parameter int GPR_W   = RS_GPR_W_DEF,
    parameter int TAG_W   = RS_TAG_W_DEF
) (
    input  logic    in_clk,
    input  logic    in_rst,
    rs_pool_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Same field order as rs_entry_t, at this instance's widths.
    typedef struct packed {
        logic             valid;
        fu_op_t           op;
        logic [TAG_W-1:0] dst_tag;
        logic             a_vld;
        logic [GPR_W-1:0] a_val;
        logic [TAG_W-1:0] a_tag;
        logic             b_vld;
        logic [GPR_W-1:0] b_val;
        logic [TAG_W-1:0] b_tag;
        logic             uses_nzcv;
        logic             set_nzcv;
        logic             f_vld;
        nzcv_t            nzcv;
        logic [TAG_W-1:0] f_tag;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    entry_t           new_ent;
    logic [CNT_W-1:0] count_q, count_d;

    logic [DEPTH-1:0] vld_vec, free_vec, alloc_oh, ready_vec, sel_oh, issue_oh;
    logic             sel_vld, alloc_rdy, do_alloc, issue_vld, do_issue;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) vld_vec[i] = ent_q[i].valid;
    end

    // Lowest-index free slot, judged on the state at cycle start.
    assign free_vec  = ~vld_vec;
    assign alloc_oh  = free_vec & (~free_vec + DEPTH'(1));
    assign alloc_rdy = (|free_vec) & ~in_rst;
    assign do_alloc  = bus.in_alloc_valid & alloc_rdy & ~bus.in_flush;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = ent_q[i].valid && ent_q[i].a_vld && ent_q[i].b_vld &&
                           (ent_q[i].f_vld || !ent_q[i].uses_nzcv) &&
                           !(ent_q[i].op == FU_OP_LDUR && bus.in_pending_stur_count != 8'd0);
        end
    end

`ifdef RS_AGE_SELECT_EN
    logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;

    rs_pool_select #(.DEPTH(DEPTH)) u_sel (
        .ready_i (ready_vec),
        .older_i (older_q),
        .grant_o (sel_oh),
        .valid_o (sel_vld)
    );

    // Issue clears the leaving entry's row/column; the new entry becomes
    // younger than everyone (row cleared, column set).
    always_comb begin
        older_d = older_q;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (issue_oh[i] || issue_oh[j]) older_d[i][j] = 1'b0;
                if (do_alloc && alloc_oh[i])    older_d[i][j] = 1'b0;
                if (do_alloc && alloc_oh[j] && i != j) older_d[i][j] = 1'b1;
            end
        end
        if (bus.in_flush) older_d = '0;
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) older_q <= '0;
        else        older_q <= older_d;
    end
`else
    rs_pool_select #(.DEPTH(DEPTH)) u_sel (
        .ready_i (ready_vec),
        .grant_o (sel_oh),
        .valid_o (sel_vld)
    );
`endif

    assign issue_vld = sel_vld & ~bus.in_flush & ~in_rst;
    assign do_issue  = issue_vld & bus.in_issue_ready;
    assign issue_oh  = do_issue ? sel_oh : '0;

    // Incoming entry, with same-cycle CDB snoop. Ports are scanned high to
    // low so the lowest matching port is the last (winning) assignment.
    always_comb begin
        new_ent           = '0;
        new_ent.valid     = 1'b1;
        new_ent.op        = bus.in_alloc_op;
        new_ent.dst_tag   = bus.in_alloc_dst_tag;
        new_ent.a_vld     = bus.in_alloc_a_valid;
        new_ent.a_val     = bus.in_alloc_a_value;
        new_ent.a_tag     = bus.in_alloc_a_tag;
        new_ent.b_vld     = bus.in_alloc_b_valid;
        new_ent.b_val     = bus.in_alloc_b_value;
        new_ent.b_tag     = bus.in_alloc_b_tag;
        new_ent.uses_nzcv = bus.in_alloc_uses_nzcv;
        new_ent.set_nzcv  = bus.in_alloc_set_nzcv;
        new_ent.f_vld     = bus.in_alloc_nzcv_valid;
        new_ent.nzcv      = bus.in_alloc_nzcv;
        new_ent.f_tag     = bus.in_alloc_nzcv_tag;
        for (int p = NUM_CDB - 1; p >= 0; p--) begin
            if (bus.in_cdb_valid[p]) begin
                if (!bus.in_alloc_a_valid && bus.in_alloc_a_tag == bus.in_cdb_tag[p]) begin
                    new_ent.a_vld = 1'b1;
                    // Memory ops hold an offset in a; the base arrives on the CDB.
                    new_ent.a_val = is_mem_op(bus.in_alloc_op) ?
                                    bus.in_alloc_a_value + bus.in_cdb_value[p] :
                                    bus.in_cdb_value[p];
                end
                if (!bus.in_alloc_b_valid && bus.in_alloc_b_tag == bus.in_cdb_tag[p]) begin
                    new_ent.b_vld = 1'b1;
                    new_ent.b_val = bus.in_cdb_value[p];
                end
                if (bus.in_cdb_set_nzcv[p] && !bus.in_alloc_nzcv_valid &&
                    bus.in_alloc_nzcv_tag == bus.in_cdb_tag[p]) begin
                    new_ent.f_vld = 1'b1;
                    new_ent.nzcv  = bus.in_cdb_nzcv[p];
                end
            end
        end
    end

    // Entry next state: wakeup, then issue, then alloc, then flush.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            for (int p = NUM_CDB - 1; p >= 0; p--) begin
                if (bus.in_cdb_valid[p]) begin
                    if (!ent_q[i].a_vld && ent_q[i].a_tag == bus.in_cdb_tag[p]) begin
                        ent_d[i].a_vld = 1'b1;
                        ent_d[i].a_val = is_mem_op(ent_q[i].op) ?
                                         ent_q[i].a_val + bus.in_cdb_value[p] :
                                         bus.in_cdb_value[p];
                    end
                    if (!ent_q[i].b_vld && ent_q[i].b_tag == bus.in_cdb_tag[p]) begin
                        ent_d[i].b_vld = 1'b1;
                        ent_d[i].b_val = bus.in_cdb_value[p];
                    end
                    if (bus.in_cdb_set_nzcv[p] && !ent_q[i].f_vld &&
                        ent_q[i].f_tag == bus.in_cdb_tag[p]) begin
                        ent_d[i].f_vld = 1'b1;
                        ent_d[i].nzcv  = bus.in_cdb_nzcv[p];
                    end
                end
            end
            if (issue_oh[i])             ent_d[i].valid = 1'b0;
            if (do_alloc && alloc_oh[i]) ent_d[i]       = new_ent;
            if (bus.in_flush)            ent_d[i].valid = 1'b0;
        end
    end

    always_comb begin
        if (bus.in_flush) count_d = '0;
        else              count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_issue);
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            count_q <= count_d;
        end
    end

    // Issue payload mux over the one-hot selection.
    always_comb begin
        bus.out_issue_op       = FU_OP_ADD;
        bus.out_issue_val_a    = '0;
        bus.out_issue_val_b    = '0;
        bus.out_issue_nzcv     = '0;
        bus.out_issue_set_nzcv = 1'b0;
        bus.out_issue_dst_tag  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) begin
                bus.out_issue_op       = ent_q[i].op;
                bus.out_issue_val_a    = ent_q[i].a_val;
                bus.out_issue_val_b    = ent_q[i].b_val;
                bus.out_issue_nzcv     = ent_q[i].nzcv;
                bus.out_issue_set_nzcv = ent_q[i].set_nzcv;
                bus.out_issue_dst_tag  = ent_q[i].dst_tag;
            end
        end
    end

    assign bus.out_issue_valid = issue_vld;
    assign bus.out_alloc_ready = alloc_rdy;
    assign bus.out_count       = in_rst ? '0 : count_q;

endmodule

// File: tb/tb_rs_pool.sv
// tb_rs_pool -- directed self-checking bench for rs_pool (default params).
// Expected issue order in the age test follows RS_AGE_SELECT_EN.
module tb_rs_pool;
    import rs_pool_pkg::*;

    logic in_clk = 1'b0;
    logic in_rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    rs_pool_if #(.DEPTH(8), .NUM_CDB(2), .GPR_W(64), .TAG_W(6)) bus ();

    rs_pool #(.DEPTH(8), .NUM_CDB(2), .GPR_W(64), .TAG_W(6)) dut (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .bus    (bus)
    );

    always #5 in_clk = ~in_clk;

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clr();
        bus.in_flush              = 1'b0;
        bus.in_alloc_valid        = 1'b0;
        bus.in_alloc_op           = FU_OP_ADD;
        bus.in_alloc_dst_tag      = '0;
        bus.in_alloc_a_valid      = 1'b0;
        bus.in_alloc_a_value      = '0;
        bus.in_alloc_a_tag        = '0;
        bus.in_alloc_b_valid      = 1'b0;
        bus.in_alloc_b_value      = '0;
        bus.in_alloc_b_tag        = '0;
        bus.in_alloc_uses_nzcv    = 1'b0;
        bus.in_alloc_set_nzcv     = 1'b0;
        bus.in_alloc_nzcv_valid   = 1'b0;
        bus.in_alloc_nzcv         = '0;
        bus.in_alloc_nzcv_tag     = '0;
        bus.in_cdb_valid          = '0;
        bus.in_cdb_tag            = '0;
        bus.in_cdb_value          = '0;
        bus.in_cdb_set_nzcv       = '0;
        bus.in_cdb_nzcv           = '0;
        bus.in_pending_stur_count = 8'd0;
        bus.in_issue_ready        = 1'b0;
    endtask

    task automatic alloc_set(input fu_op_t op, input logic [5:0] dst,
                             input logic av, input logic [63:0] aval, input logic [5:0] atag,
                             input logic bv, input logic [63:0] bval, input logic [5:0] btag);
        bus.in_alloc_valid     = 1'b1;
        bus.in_alloc_op        = op;
        bus.in_alloc_dst_tag   = dst;
        bus.in_alloc_a_valid   = av;
        bus.in_alloc_a_value   = aval;
        bus.in_alloc_a_tag     = atag;
        bus.in_alloc_b_valid   = bv;
        bus.in_alloc_b_value   = bval;
        bus.in_alloc_b_tag     = btag;
        bus.in_alloc_uses_nzcv = 1'b0;
        bus.in_alloc_set_nzcv  = 1'b0;
    endtask

    task automatic cdb(input int p, input logic [5:0] tag, input logic [63:0] val,
                       input logic setf, input logic [3:0] f);
        bus.in_cdb_valid[p]    = 1'b1;
        bus.in_cdb_tag[p]      = tag;
        bus.in_cdb_value[p]    = val;
        bus.in_cdb_set_nzcv[p] = setf;
        bus.in_cdb_nzcv[p]     = nzcv_t'(f);
    endtask

    task automatic cdb_clr();
        bus.in_cdb_valid    = '0;
        bus.in_cdb_set_nzcv = '0;
    endtask

    logic [5:0] first_dst, second_dst;

    initial begin
        clr();
        in_rst = 1'b1;
        tick();
        tick();
        chk("rst_issue_valid", 64'(bus.out_issue_valid), 64'd0);
        chk("rst_alloc_ready", 64'(bus.out_alloc_ready), 64'd0);
        chk("rst_count",       64'(bus.out_count),       64'd0);
        in_rst = 1'b0;
        #1;
        chk("idle_alloc_ready", 64'(bus.out_alloc_ready), 64'd1);
        chk("idle_count",       64'(bus.out_count),       64'd0);

        // Fully-valid ADD issues the cycle after allocation.
        alloc_set(FU_OP_ADD, 6'd10, 1'b1, 64'd5, 6'd0, 1'b1, 64'd7, 6'd0);
        #1;
        chk("add_not_same_cycle", 64'(bus.out_issue_valid), 64'd0);
        tick();
        bus.in_alloc_valid = 1'b0;
        #1;
        chk("add_issue_valid", 64'(bus.out_issue_valid),   64'd1);
        chk("add_val_a",       bus.out_issue_val_a,        64'd5);
        chk("add_val_b",       bus.out_issue_val_b,        64'd7);
        chk("add_dst",         64'(bus.out_issue_dst_tag), 64'd10);
        chk("add_count",       64'(bus.out_count),         64'd1);
        bus.in_issue_ready = 1'b1;
        tick();
        bus.in_issue_ready = 1'b0;
        #1;
        chk("add_drained_count", 64'(bus.out_count),       64'd0);
        chk("add_drained_valid", 64'(bus.out_issue_valid), 64'd0);

        // Fill all 8 entries waiting on tag 3, then wake them together.
        for (int i = 0; i < 8; i++) begin
            alloc_set(FU_OP_ADD, 6'(i), 1'b0, 64'd0, 6'd3, 1'b1, 64'd2, 6'd0);
            tick();
        end
        bus.in_alloc_valid = 1'b0;
        #1;
        chk("full_alloc_ready", 64'(bus.out_alloc_ready), 64'd0);
        chk("full_count",       64'(bus.out_count),       64'd8);
        chk("full_no_issue",    64'(bus.out_issue_valid), 64'd0);
        cdb(0, 6'd3, 64'd9, 1'b0, 4'd0);
        tick();
        cdb_clr();
        bus.in_issue_ready = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("wake_issue_valid", 64'(bus.out_issue_valid),   64'd1);
            chk("wake_val_a",       bus.out_issue_val_a,        64'd9);
            chk("wake_order_dst",   64'(bus.out_issue_dst_tag), 64'(i));
            tick();
        end
        bus.in_issue_ready = 1'b0;
        #1;
        chk("wake_drained_count", 64'(bus.out_count), 64'd0);

        // LDUR: offset 16 + base 100, held back by a pending store.
        alloc_set(FU_OP_LDUR, 6'd20, 1'b0, 64'd16, 6'd2, 1'b1, 64'd0, 6'd0);
        bus.in_pending_stur_count = 8'd1;
        tick();
        bus.in_alloc_valid = 1'b0;
        cdb(0, 6'd2, 64'd100, 1'b0, 4'd0);
        tick();
        cdb_clr();
        #1;
        chk("ldur_blocked", 64'(bus.out_issue_valid), 64'd0);
        bus.in_pending_stur_count = 8'd0;
        #1;
        chk("ldur_issue_valid", 64'(bus.out_issue_valid), 64'd1);
        chk("ldur_val_a",       bus.out_issue_val_a,      64'd116);
        chk("ldur_op",          64'(bus.out_issue_op),    64'(FU_OP_LDUR));
        bus.in_issue_ready = 1'b1;
        tick();
        bus.in_issue_ready = 1'b0;

        // Allocation snoops a same-cycle broadcast on port 1.
        alloc_set(FU_OP_ADD, 6'd21, 1'b0, 64'd0, 6'd4, 1'b1, 64'd3, 6'd0);
        cdb(1, 6'd4, 64'd11, 1'b0, 4'd0);
        cdb(0, 6'd9, 64'd55, 1'b0, 4'd0);
        tick();
        bus.in_alloc_valid = 1'b0;
        cdb_clr();
        #1;
        chk("snoop_issue_valid", 64'(bus.out_issue_valid), 64'd1);
        chk("snoop_val_a",       bus.out_issue_val_a,      64'd11);
        bus.in_issue_ready = 1'b1;
        tick();
        bus.in_issue_ready = 1'b0;

        // Same tag on both ports: port 0 wins.
        alloc_set(FU_OP_ADD, 6'd22, 1'b0, 64'd0, 6'd5, 1'b0, 64'd0, 6'd5);
        tick();
        bus.in_alloc_valid = 1'b0;
        cdb(0, 6'd5, 64'd1, 1'b0, 4'd0);
        cdb(1, 6'd5, 64'd2, 1'b0, 4'd0);
        tick();
        cdb_clr();
        #1;
        chk("prio_val_a", bus.out_issue_val_a, 64'd1);
        chk("prio_val_b", bus.out_issue_val_b, 64'd1);
        bus.in_issue_ready = 1'b1;
        tick();
        bus.in_issue_ready = 1'b0;

        // Flags wake only on a flag-setting broadcast.
        alloc_set(FU_OP_ADD, 6'd23, 1'b1, 64'd1, 6'd0, 1'b1, 64'd1, 6'd0);
        bus.in_alloc_uses_nzcv  = 1'b1;
        bus.in_alloc_set_nzcv   = 1'b1;
        bus.in_alloc_nzcv_valid = 1'b0;
        bus.in_alloc_nzcv_tag   = 6'd6;
        tick();
        bus.in_alloc_valid = 1'b0;
        cdb(0, 6'd6, 64'd77, 1'b0, 4'hF);
        tick();
        cdb_clr();
        #1;
        chk("flag_no_set_wait", 64'(bus.out_issue_valid), 64'd0);
        cdb(0, 6'd6, 64'd77, 1'b1, 4'hA);
        tick();
        cdb_clr();
        #1;
        chk("flag_issue_valid", 64'(bus.out_issue_valid),    64'd1);
        chk("flag_nzcv",        64'(bus.out_issue_nzcv),     64'hA);
        chk("flag_set_nzcv",    64'(bus.out_issue_set_nzcv), 64'd1);
        bus.in_issue_ready = 1'b1;
        tick();
        bus.in_issue_ready = 1'b0;

        // Age: X (dst 11) lands in slot 1, later Y (dst 12) in slot 0.
        alloc_set(FU_OP_ADD, 6'd30, 1'b1, 64'd0, 6'd0, 1'b1, 64'd0, 6'd0);
        tick();
        alloc_set(FU_OP_ADD, 6'd11, 1'b0, 64'd0, 6'd7, 1'b1, 64'd0, 6'd0);
        tick();
        bus.in_alloc_valid = 1'b0;
        bus.in_issue_ready = 1'b1;
        #1;
        chk("age_filler_dst", 64'(bus.out_issue_dst_tag), 64'd30);
        tick();
        bus.in_issue_ready = 1'b0;
        alloc_set(FU_OP_ADD, 6'd12, 1'b0, 64'd0, 6'd7, 1'b1, 64'd0, 6'd0);
        tick();
        bus.in_alloc_valid = 1'b0;
        cdb(0, 6'd7, 64'd5, 1'b0, 4'd0);
        tick();
        cdb_clr();
`ifdef RS_AGE_SELECT_EN
        first_dst  = 6'd11;
        second_dst = 6'd12;
`else
        first_dst  = 6'd12;
        second_dst = 6'd11;
`endif
        bus.in_issue_ready = 1'b1;
        #1;
        chk("age_first_dst", 64'(bus.out_issue_dst_tag), 64'(first_dst));
        tick();
        chk("age_second_dst", 64'(bus.out_issue_dst_tag), 64'(second_dst));
        tick();
        bus.in_issue_ready = 1'b0;
        #1;
        chk("age_drained_count", 64'(bus.out_count), 64'd0);

        // Flush with 5 entries (one ready), concurrent alloc and issue_ready.
        for (int i = 0; i < 5; i++) begin
            alloc_set(FU_OP_ADD, 6'(40 + i), (i == 0), 64'd0, 6'd50, 1'b1, 64'd0, 6'd0);
            tick();
        end
        bus.in_alloc_valid = 1'b0;
        #1;
        chk("flush_pre_count", 64'(bus.out_count), 64'd5);
        alloc_set(FU_OP_ADD, 6'd45, 1'b1, 64'd0, 6'd0, 1'b1, 64'd0, 6'd0);
        bus.in_flush       = 1'b1;
        bus.in_issue_ready = 1'b1;
        #1;
        chk("flush_no_issue", 64'(bus.out_issue_valid), 64'd0);
        tick();
        bus.in_flush       = 1'b0;
        bus.in_alloc_valid = 1'b0;
        bus.in_issue_ready = 1'b0;
        #1;
        chk("flush_count",       64'(bus.out_count),       64'd0);
        chk("flush_post_issue",  64'(bus.out_issue_valid), 64'd0);
        chk("flush_alloc_ready", 64'(bus.out_alloc_ready), 64'd1);

        // Reset wins over a concurrent alloc and issue.
        alloc_set(FU_OP_ADD, 6'd50, 1'b1, 64'd0, 6'd0, 1'b1, 64'd0, 6'd0);
        tick();
        in_rst             = 1'b1;
        bus.in_issue_ready = 1'b1;
        #1;
        chk("rst2_issue_valid", 64'(bus.out_issue_valid), 64'd0);
        chk("rst2_alloc_ready", 64'(bus.out_alloc_ready), 64'd0);
        chk("rst2_count",       64'(bus.out_count),       64'd0);
        tick();
        in_rst = 1'b0;
        clr();
        #1;
        chk("rst2_post_count", 64'(bus.out_count),       64'd0);
        chk("rst2_post_issue", 64'(bus.out_issue_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
